// File: rtl/cmp_arbiter.sv
// Round-robin arbiter granting N_REQ requesters one at a time onto a shared comparator.
// Latency: result CMP_LAT+1 edges after the grant; the response is held until rsp_ready_i and blocks new grants.
module cmp_arbiter #(
    parameter int TOP_BW  = 32,
    parameter int N_REQ   = 4,
    parameter int CMP_LAT = 0
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [N_REQ-1:0]           req_valid_i,
    output logic [N_REQ-1:0]           req_ready_o,
    input  logic [N_REQ*TOP_BW-1:0]    req_opA_i,
    input  logic [N_REQ*TOP_BW-1:0]    req_opB_i,
    output logic [TOP_BW-1:0]          opA_o,
    output logic [TOP_BW-1:0]          opB_o,
    input  logic                       match_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [$clog2(N_REQ)-1:0]   rsp_id_o,
    output logic                       rsp_match_o,
    output logic                       busy_o,
    output logic [15:0]                match_cnt_o
);

    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [TOP_BW-1:0]  opa_q, opa_d;
    logic [TOP_BW-1:0]  opb_q, opb_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic               rsp_match_q, rsp_match_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [15:0]        match_cnt_q, match_cnt_d;

    logic [IDW-1:0]     winner;
    logic               any_vld;
    logic [N_REQ-1:0]   grant_oh;

    // Search starts just past the last grant so every requester gets a turn.
    always_comb begin
        winner  = '0;
        any_vld = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_vld && req_valid_i[(int'(last_grant_q) + 1 + i) % N_REQ]) begin
                any_vld = 1'b1;
                winner  = IDW'((int'(last_grant_q) + 1 + i) % N_REQ);
            end
        end
    end

    assign grant_oh = any_vld ? ({{(N_REQ-1){1'b0}}, 1'b1} << winner) : '0;

    // Gating with resetn keeps ready low while reset is held, even though state reads IDLE.
    assign req_ready_o = (resetn && state_q == S_IDLE) ? grant_oh : '0;
    assign busy_o      = (state_q != S_IDLE);
    assign opA_o       = opa_q;
    assign opB_o       = opb_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_match_o = rsp_match_q;
    assign rsp_valid_o = rsp_valid_q;
    assign match_cnt_o = match_cnt_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        rsp_id_d     = rsp_id_q;
        rsp_match_d  = rsp_match_q;
        rsp_valid_d  = rsp_valid_q;
        match_cnt_d  = match_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (any_vld) begin
                    opa_d        = req_opA_i[int'(winner)*TOP_BW +: TOP_BW];
                    opb_d        = req_opB_i[int'(winner)*TOP_BW +: TOP_BW];
                    rsp_id_d     = winner;
                    last_grant_d = winner;
                    cnt_d        = 3'(CMP_LAT);
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    rsp_match_d = match_i;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    if (rsp_match_q && match_cnt_q != 16'hFFFF) begin
                        match_cnt_d = match_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDW'(N_REQ - 1);
            cnt_q        <= 3'd0;
            opa_q        <= '0;
            opb_q        <= '0;
            rsp_id_q     <= '0;
            rsp_match_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            match_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            rsp_id_q     <= rsp_id_d;
            rsp_match_q  <= rsp_match_d;
            rsp_valid_q  <= rsp_valid_d;
            match_cnt_q  <= match_cnt_d;
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: one instance with CMP_LAT=0 and a real comparator, one with CMP_LAT=3 and a driven match.
module tb_cmp_arbiter;

    logic         clock;
    logic         resetn;

    logic [3:0]   vld0, rdy0;
    logic [127:0] rqa0, rqb0;
    logic [31:0]  opa0, opb0;
    logic         mt0, rv0, rr0, rm0, bz0;
    logic [1:0]   id0;
    logic [15:0]  mc0;

    logic [3:0]   vld3, rdy3;
    logic [127:0] rqa3, rqb3;
    logic [31:0]  opa3, opb3;
    logic         mt3, rv3, rr3, rm3, bz3;
    logic [1:0]   id3;
    logic [15:0]  mc3;

    int vecs = 0;
    int errs = 0;

    assign mt0 = (opa0 == opb0);

    cmp_arbiter #(.TOP_BW(32), .N_REQ(4), .CMP_LAT(0)) u_dut0 (
        .clock(clock), .resetn(resetn),
        .req_valid_i(vld0), .req_ready_o(rdy0), .req_opA_i(rqa0), .req_opB_i(rqb0),
        .opA_o(opa0), .opB_o(opb0), .match_i(mt0),
        .rsp_valid_o(rv0), .rsp_ready_i(rr0), .rsp_id_o(id0), .rsp_match_o(rm0),
        .busy_o(bz0), .match_cnt_o(mc0)
    );

    cmp_arbiter #(.TOP_BW(32), .N_REQ(4), .CMP_LAT(3)) u_dut3 (
        .clock(clock), .resetn(resetn),
        .req_valid_i(vld3), .req_ready_o(rdy3), .req_opA_i(rqa3), .req_opB_i(rqb3),
        .opA_o(opa3), .opB_o(opb3), .match_i(mt3),
        .rsp_valid_o(rv3), .rsp_ready_i(rr3), .rsp_id_o(id3), .rsp_match_o(rm3),
        .busy_o(bz3), .match_cnt_o(mc3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic reset_pulse();
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        vld0 = 4'hF; vld3 = 4'hF;
        #2;
        vecs++; if (rdy0 !== 4'b0000) begin errs++; $display("FAIL rst_ready0: got %b want 0000", rdy0); end
        vecs++; if (bz0 !== 1'b0) begin errs++; $display("FAIL rst_busy0: got %b want 0", bz0); end
        vecs++; if (rv0 !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid0: got %b want 0", rv0); end
        vecs++; if (rm0 !== 1'b0) begin errs++; $display("FAIL rst_rsp_match0: got %b want 0", rm0); end
        vecs++; if (id0 !== 2'd0) begin errs++; $display("FAIL rst_rsp_id0: got %0d want 0", id0); end
        vecs++; if (opa0 !== 32'd0 || opb0 !== 32'd0) begin errs++; $display("FAIL rst_ops0: got %h/%h want 0/0", opa0, opb0); end
        vecs++; if (mc0 !== 16'd0) begin errs++; $display("FAIL rst_cnt0: got %h want 0", mc0); end
        vecs++; if (rdy3 !== 4'b0000 || bz3 !== 1'b0 || rv3 !== 1'b0) begin errs++; $display("FAIL rst_dut3: got rdy=%b busy=%b rv=%b want 0", rdy3, bz3, rv3); end
        @(negedge clock);
        vld0 = 4'h0; vld3 = 4'h0;
        resetn = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clock);
        rqa0[2*32 +: 32] = 32'h1234; rqb0[2*32 +: 32] = 32'h1234;
        vld0 = 4'b0100;
        #1;
        vecs++; if (rdy0 !== 4'b0100) begin errs++; $display("FAIL single_ready: got %b want 0100", rdy0); end
        @(negedge clock);
        vld0 = 4'b0000;
        vecs++; if (bz0 !== 1'b1 || rv0 !== 1'b0) begin errs++; $display("FAIL single_wait: got busy=%b rv=%b want 1/0", bz0, rv0); end
        vecs++; if (opa0 !== 32'h1234) begin errs++; $display("FAIL single_opa: got %h want 1234", opa0); end
        @(negedge clock);
        vecs++; if (rv0 !== 1'b1 || id0 !== 2'd2 || rm0 !== 1'b1) begin errs++; $display("FAIL single_rsp: got rv=%b id=%0d m=%b want 1/2/1", rv0, id0, rm0); end
        rr0 = 1'b1;
        @(negedge clock);
        rr0 = 1'b0;
        vecs++; if (rv0 !== 1'b0 || bz0 !== 1'b0) begin errs++; $display("FAIL single_done: got rv=%b busy=%b want 0/0", rv0, bz0); end
        vecs++; if (mc0 !== 16'd1) begin errs++; $display("FAIL single_cnt: got %0d want 1", mc0); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_oh;
        int k;
        reset_pulse();
        for (int j = 0; j < 4; j++) begin
            rqa0[j*32 +: 32] = j;
            rqb0[j*32 +: 32] = (j % 2 == 0) ? j : j + 100;
        end
        @(negedge clock);
        vld0 = 4'hF; rr0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            k = i % 4;
            exp_oh = 4'b0001 << k;
            if (i > 0) @(negedge clock);
            #1;
            vecs++; if (rdy0 !== exp_oh) begin errs++; $display("FAIL rr_grant%0d: got %b want %b", i, rdy0, exp_oh); end
            @(negedge clock);
            vecs++; if (rdy0 !== 4'b0000 || rv0 !== 1'b0) begin errs++; $display("FAIL rr_wait%0d: got rdy=%b rv=%b want 0000/0", i, rdy0, rv0); end
            @(negedge clock);
            vecs++; if (rdy0 !== 4'b0000 || rv0 !== 1'b1 || id0 !== 2'(k) || rm0 !== (k % 2 == 0)) begin
                errs++; $display("FAIL rr_rsp%0d: got rdy=%b rv=%b id=%0d m=%b want 0000/1/%0d/%0d", i, rdy0, rv0, id0, rm0, k, (k % 2 == 0));
            end
        end
        @(negedge clock);
        vld0 = 4'h0; rr0 = 1'b0;
        #1;
        vecs++; if (bz0 !== 1'b0 || mc0 !== 16'd3) begin errs++; $display("FAIL rr_end: got busy=%b cnt=%0d want 0/3", bz0, mc0); end
    endtask

    task automatic test_backpressure();
        @(negedge clock);
        vld0 = 4'b0010;
        #1;
        vecs++; if (rdy0 !== 4'b0010) begin errs++; $display("FAIL bp_grant: got %b want 0010", rdy0); end
        @(negedge clock);
        vld0 = 4'hF;
        rqa0[1*32 +: 32] = 32'd55;
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            vecs++; if (rv0 !== 1'b1 || id0 !== 2'd1 || rm0 !== 1'b0 || rdy0 !== 4'b0000 || opa0 !== 32'd1) begin
                errs++; $display("FAIL bp_hold%0d: got rv=%b id=%0d m=%b rdy=%b opa=%0d want 1/1/0/0000/1", i, rv0, id0, rm0, rdy0, opa0);
            end
            @(negedge clock);
        end
        rr0 = 1'b1;
        #1;
        vecs++; if (rdy0 !== 4'b0000) begin errs++; $display("FAIL bp_accept_nogrant: got %b want 0000", rdy0); end
        @(negedge clock);
        rr0 = 1'b0;
        #1;
        vecs++; if (bz0 !== 1'b0 || rv0 !== 1'b0 || rdy0 !== 4'b0100) begin errs++; $display("FAIL bp_idle: got busy=%b rv=%b rdy=%b want 0/0/0100", bz0, rv0, rdy0); end
        vld0 = 4'h0;
        vecs++; if (mc0 !== 16'd3) begin errs++; $display("FAIL bp_cnt: got %0d want 3", mc0); end
        rqa0[1*32 +: 32] = 32'd1;
    endtask

    task automatic test_drop();
        @(negedge clock);
        vld0 = 4'b0101;
        #1;
        vecs++; if (rdy0 !== 4'b0100) begin errs++; $display("FAIL drop_first: got %b want 0100", rdy0); end
        vld0 = 4'b0001;
        #1;
        vecs++; if (rdy0 !== 4'b0001) begin errs++; $display("FAIL drop_skip: got %b want 0001", rdy0); end
        @(negedge clock);
        vld0 = 4'b0000;
        vecs++; if (id0 !== 2'd0 || bz0 !== 1'b1) begin errs++; $display("FAIL drop_id: got id=%0d busy=%b want 0/1", id0, bz0); end
        @(negedge clock);
        rr0 = 1'b1;
        vecs++; if (rv0 !== 1'b1 || rm0 !== 1'b1) begin errs++; $display("FAIL drop_rsp: got rv=%b m=%b want 1/1", rv0, rm0); end
        @(negedge clock);
        rr0 = 1'b0;
        vecs++; if (mc0 !== 16'd4) begin errs++; $display("FAIL drop_cnt: got %0d want 4", mc0); end
    endtask

    task automatic test_latency();
        @(negedge clock);
        rqa3[0 +: 32] = 32'h5; rqb3[0 +: 32] = 32'h6;
        vld3 = 4'b0001; mt3 = 1'b0;
        #1;
        vecs++; if (rdy3 !== 4'b0001) begin errs++; $display("FAIL lat_grant: got %b want 0001", rdy3); end
        for (int j = 1; j <= 3; j++) begin
            @(negedge clock);
            vld3 = 4'b0000;
            mt3 = (j % 2 == 1);
            vecs++; if (rv3 !== 1'b0 || bz3 !== 1'b1) begin errs++; $display("FAIL lat_early%0d: got rv=%b busy=%b want 0/1", j, rv3, bz3); end
        end
        @(negedge clock);
        mt3 = 1'b0;
        vecs++; if (rv3 !== 1'b0) begin errs++; $display("FAIL lat_e3: got rv=%b want 0", rv3); end
        @(negedge clock);
        mt3 = 1'b1;
        vecs++; if (rv3 !== 1'b1 || rm3 !== 1'b0 || id3 !== 2'd0) begin errs++; $display("FAIL lat_rsp: got rv=%b m=%b id=%0d want 1/0/0", rv3, rm3, id3); end
        rr3 = 1'b1;
        @(negedge clock);
        rr3 = 1'b0; mt3 = 1'b0;
        vecs++; if (rv3 !== 1'b0 || mc3 !== 16'd0) begin errs++; $display("FAIL lat_done: got rv=%b cnt=%0d want 0/0", rv3, mc3); end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clock);
        rqa3[1*32 +: 32] = 32'd7; rqb3[1*32 +: 32] = 32'd7;
        vld3 = 4'b0010;
        #1;
        vecs++; if (rdy3 !== 4'b0010) begin errs++; $display("FAIL mrst_grant: got %b want 0010", rdy3); end
        @(negedge clock);
        vld3 = 4'b1001;
        vecs++; if (bz3 !== 1'b1 || opa3 !== 32'd7) begin errs++; $display("FAIL mrst_wait: got busy=%b opa=%0d want 1/7", bz3, opa3); end
        #2;
        resetn = 1'b0;
        #1;
        vecs++; if (bz3 !== 1'b0 || rv3 !== 1'b0 || rm3 !== 1'b0 || id3 !== 2'd0) begin errs++; $display("FAIL mrst_ctl: got busy=%b rv=%b m=%b id=%0d want 0/0/0/0", bz3, rv3, rm3, id3); end
        vecs++; if (opa3 !== 32'd0 || opb3 !== 32'd0 || mc3 !== 16'd0 || rdy3 !== 4'b0000) begin errs++; $display("FAIL mrst_data: got opa=%h opb=%h cnt=%0d rdy=%b want 0", opa3, opb3, mc3, rdy3); end
        @(negedge clock);
        resetn = 1'b1;
        #1;
        vecs++; if (rdy3 !== 4'b0001) begin errs++; $display("FAIL mrst_first: got %b want 0001", rdy3); end
        @(negedge clock);
        vld3 = 4'b0000; rr3 = 1'b1;
        repeat (5) @(negedge clock);
        rr3 = 1'b0;
        vecs++; if (bz3 !== 1'b0 || id3 !== 2'd0) begin errs++; $display("FAIL mrst_drain: got busy=%b id=%0d want 0/0", bz3, id3); end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_cnt;
        @(negedge clock);
        force u_dut0.match_cnt_q = 16'hFFFD;
        #1;
        release u_dut0.match_cnt_q;
        vecs++; if (mc0 !== 16'hFFFD) begin errs++; $display("FAIL sat_preload: got %h want FFFD", mc0); end
        rqa0[0 +: 32] = 32'h77; rqb0[0 +: 32] = 32'h77;
        exp_cnt = 16'hFFFD;
        for (int i = 0; i < 3; i++) begin
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            @(negedge clock);
            vld0 = 4'b0001; rr0 = 1'b1;
            @(negedge clock);
            vld0 = 4'b0000;
            @(negedge clock);
            @(negedge clock);
            vecs++; if (mc0 !== exp_cnt) begin errs++; $display("FAIL sat_step%0d: got %h want %h", i, mc0, exp_cnt); end
        end
        rr0 = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        vld0 = '0; rqa0 = '0; rqb0 = '0; rr0 = 1'b0;
        vld3 = '0; rqa3 = '0; rqb3 = '0; rr3 = 1'b0; mt3 = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_drop();
        test_latency();
        test_reset_mid_wait();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
